// File: rtl/data_sram_resp.sv
// data_sram_resp: stand-in for the CPU data RAM on the execute-stage SRAM port.
// Handles byte-lane writes and fully pipelined reads with a fixed read latency.
// It also keeps debug counters and a sticky out-of-range error flag.
//
// Ports:
//   clk, reset        - clock; synchronous active-high reset
//   data_sram_en      - request valid this cycle
//   data_sram_we      - byte write enables (0 = read)
//   data_sram_addr    - byte address
//   data_sram_wdata   - write data, lane i = wdata[8i+7:8i]
//   data_sram_rdata   - read data; holds the last returned value between reads
//   data_sram_rvalid  - one-cycle pulse per completed read
//   addr_err          - sticky flag for accepted out-of-range requests
//   rd_cnt, wr_cnt    - accepted read / write counts (wrapping)
module data_sram_resp #(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        data_sram_rvalid,
  output logic        addr_err,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  if (RD_LATENCY == 0 || RD_LATENCY > 4) begin : gen_bad_latency
    $error("data_sram_resp: RD_LATENCY must be within 1..4");
  end

  // Address decode
  logic [31:0]           off;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  in_range;
  logic                  rd_acc;
  logic                  wr_acc;

  always_comb begin
    off      = data_sram_addr - BASE_ADDR;
    idx      = off[ADDR_WIDTH+1:2];
    in_range = (off >> (ADDR_WIDTH + 2)) == 32'd0;
    rd_acc   = data_sram_en && !reset && (data_sram_we == 4'd0);
    wr_acc   = data_sram_en && !reset && (data_sram_we != 4'd0);
  end

  // Storage array; deliberately not reset so contents survive a reset pulse.
  logic [31:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (wr_acc && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_we[i]) begin
          mem_q[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  logic [31:0] rd_word;

  always_comb begin
    rd_word = in_range ? mem_q[idx] : 32'd0;
  end

  // Read latency pipe. Each data stage only loads when its incoming valid is set,
  // so the last stage naturally holds the most recently returned word.
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [31:0]           dat_q [RD_LATENCY];
  logic [31:0]           dat_d [RD_LATENCY];

  always_comb begin
    vld_d    = vld_q;
    dat_d    = dat_q;
    vld_d[0] = rd_acc;
    if (rd_acc) begin
      dat_d[0] = rd_word;
    end
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      if (vld_q[i-1]) begin
        dat_d[i] = dat_q[i-1];
      end
    end
  end

  // Debug state
  logic        err_q, err_d;
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  always_comb begin
    err_d    = err_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if ((rd_acc || wr_acc) && !in_range) begin
      err_d = 1'b1;
    end
    if (rd_acc) begin
      rd_cnt_d = rd_cnt_q + 32'd1;
    end
    if (wr_acc) begin
      wr_cnt_d = wr_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q    <= '0;
      dat_q    <= '{default: '0};
      err_q    <= 1'b0;
      rd_cnt_q <= 32'd0;
      wr_cnt_q <= 32'd0;
    end else begin
      vld_q    <= vld_d;
      dat_q    <= dat_d;
      err_q    <= err_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  always_comb begin
    data_sram_rdata  = dat_q[RD_LATENCY-1];
    data_sram_rvalid = vld_q[RD_LATENCY-1];
    addr_err         = err_q;
    rd_cnt           = rd_cnt_q;
    wr_cnt           = wr_cnt_q;
  end

endmodule
